// File: rtl/hpf_beat_detector.sv
// Heartbeat peak detector on the HPF sample stream: adaptive threshold, refractory window,
// beat interval in samples and BPM via a 20-step restoring divider. Define BPM_AVG_EN to average 4 intervals.
module hpf_beat_detector #(
    parameter int Width   = 10,
    parameter int FS_HZ   = 250,
    parameter int THR_MIN = 32,
    parameter int REFRACT = 50,
    parameter int MIN_INT = 75,
    parameter int MAX_INT = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [Width-1:0] x_in,
    output logic                    beat_pulse,
    output logic [15:0]             interval,
    output logic                    interval_valid,
    output logic [7:0]              bpm,
    output logic                    bpm_valid,
    output logic signed [Width-1:0] thr
);
    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_PEAK   = 2'd1;
    localparam logic [1:0] S_REFR   = 2'd2;

    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
    localparam logic [19:0] K_NUM = 20'(60 * FS_HZ);
    localparam logic signed [Width-1:0] THR_FLOOR = Width'(THR_MIN);

    logic [1:0]              state;
    logic signed [Width-1:0] peak;
    logic [RW-1:0]           rcnt;
    logic [15:0]             icnt;
    logic                    first;

    logic signed [Width-1:0] pk_new, pk_half, thr_beat;
    logic [15:0]             icnt_inc;
    logic                    beat_ev, in_rng, iv_ev;

    always_comb begin
        pk_new   = (x_in > peak) ? x_in : peak;
        pk_half  = pk_new >>> 1;
        thr_beat = (pk_half > THR_FLOOR) ? pk_half : THR_FLOOR;
        icnt_inc = (icnt == 16'hFFFF) ? icnt : icnt + 16'd1;
        beat_ev  = en && (state == S_PEAK) && !(x_in > thr);
        in_rng   = (icnt_inc >= 16'(MIN_INT)) && (icnt_inc <= 16'(MAX_INT));
        iv_ev    = beat_ev && !first && in_rng;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_SEARCH;
            peak           <= '0;
            rcnt           <= '0;
            icnt           <= '0;
            first          <= 1'b1;
            thr            <= THR_FLOOR;
            interval       <= '0;
            beat_pulse     <= 1'b0;
            interval_valid <= 1'b0;
        end else begin
            beat_pulse     <= 1'b0;
            interval_valid <= 1'b0;
            if (en) begin
                icnt <= beat_ev ? 16'd0 : icnt_inc;
                case (state)
                    S_SEARCH: begin
                        // compare uses the pre-decrement threshold
                        if (thr > THR_FLOOR) thr <= thr - Width'(1);
                        if (x_in > thr) begin
                            state <= S_PEAK;
                            peak  <= x_in;
                        end
                    end
                    S_PEAK: begin
                        peak <= pk_new;
                        if (beat_ev) begin
                            thr        <= thr_beat;
                            rcnt       <= RW'(REFRACT - 1);
                            state      <= S_REFR;
                            beat_pulse <= 1'b1;
                            first      <= 1'b0;
                            if (!first) begin
                                interval       <= icnt_inc;
                                interval_valid <= in_rng;
                            end
                        end
                    end
                    S_REFR: begin
                        if (rcnt == '0) state <= S_SEARCH;
                        else            rcnt  <= rcnt - RW'(1);
                    end
                    default: state <= S_SEARCH;
                endcase
            end
        end
    end

    logic [15:0] div_in;
    logic        launch;

`ifdef BPM_AVG_EN
    logic [3:0][15:0] hist;
    logic [2:0]       hcnt;
    logic [17:0]      hsum;

    always_comb hsum = 18'(hist[0]) + 18'(hist[1]) + 18'(hist[2]) + 18'(hist[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            hcnt <= '0;
        end else if (iv_ev) begin
            hist <= {hist[2:0], icnt_inc};
            if (hcnt != 3'd4) hcnt <= hcnt + 3'd1;
        end
    end

    assign div_in = hsum[17:2];
    assign launch = interval_valid && (hcnt == 3'd4);
`else
    assign div_in = interval;
    assign launch = interval_valid;
`endif

    // Restoring divider: quotient bits shift in from the right as dividend bits shift out the top.
    logic        busy;
    logic [4:0]  dcnt;
    logic [15:0] rem, dvs;
    logic [19:0] quo;
    logic [16:0] rem_sh;
    logic        ge;
    logic [15:0] rem_nx;
    logic [19:0] quo_nx;

    always_comb begin
        rem_sh = {rem, quo[19]};
        ge     = rem_sh >= {1'b0, dvs};
        rem_nx = ge ? (rem_sh[15:0] - dvs) : rem_sh[15:0];
        quo_nx = {quo[18:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            dcnt      <= '0;
            rem       <= '0;
            dvs       <= '0;
            quo       <= '0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
        end else begin
            bpm_valid <= 1'b0;
            if (launch) begin
                busy <= 1'b1;
                dcnt <= 5'd20;
                rem  <= '0;
                quo  <= K_NUM;
                dvs  <= div_in;
            end else if (busy) begin
                rem  <= rem_nx;
                quo  <= quo_nx;
                dcnt <= dcnt - 5'd1;
                if (dcnt == 5'd1) begin
                    busy      <= 1'b0;
                    bpm       <= (quo_nx > 20'd255) ? 8'hFF : quo_nx[7:0];
                    bpm_valid <= 1'b1;
                end
            end
        end
    end

    logic unused_iv;
    assign unused_iv = iv_ev;
endmodule

// File: tb/tb_hpf_beat_detector.sv
// Scoreboard bench for hpf_beat_detector: expected beats/BPM queued at stimulus time, checked on output pulses.
module tb_hpf_beat_detector;
    localparam int W = 10;
    localparam int KN = 15000;

    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
    logic signed [W-1:0] x_in = '0;
    logic beat_pulse, interval_valid, bpm_valid;
    logic [15:0] interval;
    logic [7:0]  bpm;
    logic signed [W-1:0] thr;

    hpf_beat_detector #(.Width(W), .FS_HZ(250), .THR_MIN(32), .REFRACT(50),
                        .MIN_INT(75), .MAX_INT(500)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .x_in(x_in),
        .beat_pulse(beat_pulse), .interval(interval), .interval_valid(interval_valid),
        .bpm(bpm), .bpm_valid(bpm_valid), .thr(thr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    typedef struct {int cyc; int ival; int iv;} beat_t;
    beat_t beat_q[$];
    int    bpm_q[$];
    int    hist[$];
    int    per = 4, samp = 0, last_ev = 0, iv_cyc = 0, bpm_seen = 0;
    bit    first = 1'b1;

    // Monitor samples on the falling edge, away from the active edge.
    beat_t e;
    always @(negedge clk) if (rst_n) begin
        if (beat_pulse) begin
            if (beat_q.size() == 0) chk("beat_unexp", 1, 0);
            else begin
                e = beat_q.pop_front();
                chk("beat_cyc", cyc, e.cyc);
                chk("interval", int'(interval), e.ival);
                chk("ival", int'(interval_valid), e.iv);
                chk("thr_after_beat", int'(thr), 150);
            end
        end else if (interval_valid) chk("ival_alone", 1, 0);
        if (interval_valid) iv_cyc = cyc;
        if (bpm_valid) begin
            bpm_seen++;
            if (bpm_q.size() == 0) chk("bpm_unexp", 1, 0);
            else chk("bpm", int'(bpm), bpm_q.pop_front());
            chk("bpm_lat", cyc - iv_cyc, 21);
        end
    end

    task automatic model_bpm(input int g);
        int d;
`ifdef BPM_AVG_EN
        hist.push_back(g);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4) begin
            d = (hist[0] + hist[1] + hist[2] + hist[3]) >> 2;
            bpm_q.push_back((KN / d > 255) ? 255 : KN / d);
        end
`else
        d = g;
        bpm_q.push_back((KN / d > 255) ? 255 : KN / d);
`endif
    endtask

    task automatic expect_beat();
        beat_t b;
        int g;
        b.cyc = cyc + 1;
        if (first) begin
            b.ival = 0; b.iv = 0; first = 1'b0;
        end else begin
            g = samp - last_ev;
            if (g > 65535) g = 65535;
            b.ival = g;
            b.iv = (g >= 75 && g <= 500) ? 1 : 0;
            if (b.iv != 0) model_bpm(g);
        end
        last_ev = samp;
        beat_q.push_back(b);
    endtask

    task automatic drive(input int v, input bit ev);
        @(negedge clk);
        en = 1'b1; x_in = W'(v); samp++;
        if (ev) expect_beat();
        repeat (per - 1) begin
            @(negedge clk); en = 1'b0; x_in = '0;
        end
    endtask

    task automatic idle_to(input int target);
        while (samp < target) drive(0, 1'b0);
    endtask

    // Sharp triangle: the trailing zero is always the beat-event sample while thr < 150.
    task automatic pulse_gap(input int g);
        idle_to(last_ev + g - 4);
        drive(150, 1'b0); drive(300, 1'b0); drive(150, 1'b0); drive(0, 1'b1);
    endtask

    task automatic spike();
        drive(150, 1'b0); drive(300, 1'b0); drive(150, 1'b0); drive(0, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk); en = 1'b0; x_in = '0;
    endtask

    task automatic do_reset(input string tag);
        int bs;
        @(negedge clk);
        en = 1'b0; x_in = '0; rst_n = 1'b0;
        beat_q.delete(); bpm_q.delete(); hist.delete();
        first = 1'b1; last_ev = samp;
        #1;
        chk({tag, "_thr"}, int'(thr), 32);
        chk({tag, "_pulses"}, int'({beat_pulse, interval_valid, bpm_valid}), 0);
        chk({tag, "_bpm"}, int'(bpm), 0);
        chk({tag, "_interval"}, int'(interval), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bs = bpm_seen;
        repeat (40) @(negedge clk);
        chk({tag, "_no_bpm_after"}, bpm_seen - bs, 0);
    endtask

    int b;
    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_thr", int'(thr), 32);
        chk("rst_pulses", int'({beat_pulse, interval_valid, bpm_valid}), 0);
        chk("rst_bpm", int'(bpm), 0);
        chk("rst_interval", int'(interval), 0);
        rst_n = 1'b1;

        // regular beats then rate change, en every 4 clk
        per = 4;
        pulse_gap(10);
        repeat (4) pulse_gap(250);
        repeat (3) pulse_gap(200);
        repeat (5) @(negedge clk);
        do_reset("rst_mid_div");

        // mid-peak reset, then en every clk
        per = 1;
        drive(150, 1'b0); drive(300, 1'b0);
        do_reset("rst_mid_peak");

        pulse_gap(20);
        pulse_gap(240); pulse_gap(260); pulse_gap(250); pulse_gap(250);
        pulse_gap(250);

        // spike inside refractory, then a too-close beat and a too-long gap
        b = last_ev;
        idle_to(b + 26);
        spike();
        pulse_gap(60);
        pulse_gap(600);

        b = last_ev;
        idle_to(b + 60); settle();
        chk("thr_decay", int'(thr), 140);
        idle_to(b + 1000); settle();
        chk("thr_floor", int'(thr), 32);

        pulse_gap(66000);
        pulse_gap(250);
        settle();
        repeat (30) @(negedge clk);

        chk("beat_q_left", beat_q.size(), 0);
        chk("bpm_q_left", bpm_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
